axi_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of axi_master and drives its start_write/start_read/addr_in/data_in control interface. It buffers software- or test-generated read/write commands in a command FIFO and issues them to the master one at a time. It collects done/error/data_out into a response FIFO, so producers can queue traffic without tracking master timing. It also provides a transaction timeout watchdog.

---
 rtl/axi_seq_pkg.sv | 27 ++
 rtl/seq_sync_fifo.sv | 58 +++++
 rtl/axi_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_axi_cmd_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_seq_pkg.sv
// Shared types and width helpers for the AXI command sequencer.
package axi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_HALT
    } seq_state_e;

    // Command record: {write, addr, wdata}
    function automatic int unsigned cmd_rec_w(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

    // Response record: {write, error, rdata}
    function automatic int unsigned rsp_rec_w(input int unsigned dw);
        return 2 + dw;
    endfunction

    // Watchdog counter must be able to hold the timeout value itself.
    function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/seq_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and an occupancy count.
module seq_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == PW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + PW'(do_push) - PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Queues read/write commands, issues them one at a time to axi_master,
// collects responses and guards each transaction with a watchdog.
module axi_cmd_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  start_write,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  done,
    input  logic                  error,
    output logic                  busy,
    output logic                  timeout
);
    import axi_seq_pkg::*;

    localparam int unsigned CMD_W  = cmd_rec_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned RSP_W  = rsp_rec_w(DATA_WIDTH);
    localparam int unsigned CNT_W  = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RSP_CW = $clog2(RSP_DEPTH) + 1;

    logic [CMD_W-1:0]      cmd_push_rec;
    logic [CMD_W-1:0]      cmd_head;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic                  cmd_pop;
    logic [CMD_CW-1:0]     cmd_count;

    logic [RSP_W-1:0]      rsp_push_rec;
    logic [RSP_W-1:0]      rsp_head;
    logic                  rsp_full;
    logic                  rsp_empty;
    logic                  rsp_push;
    logic [RSP_CW-1:0]     rsp_count;
    logic [DATA_WIDTH-1:0] wait_rdata_c;

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  write_q, write_d;
    logic                  start_write_q, start_write_d;
    logic                  start_read_q, start_read_d;
    logic                  timeout_q, timeout_d;

    assign cmd_push_rec = {cmd_write, cmd_addr, cmd_wdata};
    assign cmd_ready    = !cmd_full;

    seq_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata (cmd_push_rec),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    seq_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push && !rsp_full),
        .wdata (rsp_push_rec),
        .pop   (rsp_valid && rsp_ready),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid                          = !rsp_empty;
    assign {rsp_write, rsp_error, rsp_rdata}  = rsp_head;
    assign wait_rdata_c = write_q ? '0 : data_out;

    assign start_write = start_write_q;
    assign start_read  = start_read_q;
    assign addr_in     = addr_q;
    assign data_in     = data_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q != ST_IDLE) || (cmd_count != '0);

    // Next-state and registered-output logic; a response slot is reserved before issue.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        write_d       = write_q;
        start_write_d = 1'b0;
        start_read_d  = 1'b0;
        timeout_d     = timeout_q;
        cmd_pop       = 1'b0;
        rsp_push      = 1'b0;
        rsp_push_rec  = '0;

        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty && (rsp_count < RSP_CW'(RSP_DEPTH)) && !done) begin
                    cmd_pop                   = 1'b1;
                    {write_d, addr_d, data_d} = cmd_head;
                    start_write_d             = cmd_head[CMD_W-1];
                    start_read_d              = !cmd_head[CMD_W-1];
                    cnt_d                     = '0;
                    state_d                   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    rsp_push     = 1'b1;
                    rsp_push_rec = {write_q, error, wait_rdata_c};
                    cnt_d        = '0;
                    state_d      = ST_DRAIN;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    rsp_push     = 1'b1;
                    rsp_push_rec = {write_q, 1'b1, {DATA_WIDTH{1'b0}}};
                    timeout_d    = 1'b1;
                    state_d      = ST_HALT;
                end
            end
            // Wait out a level-held done so it yields exactly one response.
            ST_DRAIN: begin
                if (!done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            write_q       <= 1'b0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            write_q       <= write_d;
            start_write_q <= start_write_d;
            start_read_q  <= start_read_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Directed bench for axi_cmd_sequencer with a small axi_master responder model.
module tb_axi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic        start_write, start_read;
    logic [31:0] addr_in, data_in, data_out;
    logic        done, err_drv, busy, timeout;

    int n_vec = 0;
    int n_err = 0;

    axi_cmd_sequencer #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CMD_DEPTH      (4),
        .RSP_DEPTH      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .start_write (start_write),
        .start_read  (start_read),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .done        (done),
        .error       (err_drv),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Start-pulse monitor: counts pulses, flags overlaps and pulses wider than one cycle.
    int   sw_cnt = 0, sr_cnt = 0, pulse_err = 0;
    logic prev_sw = 1'b0, prev_sr = 1'b0;
    always @(posedge clk) begin
        if (start_write === 1'b1) sw_cnt <= sw_cnt + 1;
        if (start_read === 1'b1)  sr_cnt <= sr_cnt + 1;
        if ((start_write === 1'b1 && start_read === 1'b1) ||
            (start_write === 1'b1 && prev_sw) || (start_read === 1'b1 && prev_sr))
            pulse_err <= pulse_err + 1;
        prev_sw <= (start_write === 1'b1);
        prev_sr <= (start_read === 1'b1);
    end

    // Master model: done one cycle, two cycles after the start pulse; small memory.
    bit          master_en = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] man_data = 32'h0;
    logic        auto_done = 1'b0;
    logic [31:0] auto_data = 32'h0;
    logic        lat_w = 1'b0;
    logic [3:0]  lat_idx = 4'h0;
    int          cd = 0;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        auto_done <= 1'b0;
        if (rst || !master_en) begin
            cd <= 0;
        end else if (start_write === 1'b1 || start_read === 1'b1) begin
            cd      <= 2;
            lat_w   <= start_write;
            lat_idx <= addr_in[5:2];
            if (start_write === 1'b1) mem[addr_in[5:2]] <= data_in;
        end else if (cd == 1) begin
            auto_done <= 1'b1;
            auto_data <= lat_w ? 32'hBAD0_BAD0 : mem[lat_idx];
            cd        <= 0;
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
    end

    assign done     = auto_done | man_done;
    assign data_out = man_done ? man_data : auto_data;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        ok = (cmd_ready === 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(output logic w, output logic e, output logic [31:0] d, output bit ok);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        ok = (rsp_valid === 1'b1);
        w = rsp_write; e = rsp_error; d = rsp_rdata;
        if (ok) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (start_write !== 1'b1 && start_read !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        ok = (start_write === 1'b1 || start_read === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_vec++;
        if ({cmd_ready, rsp_valid, busy, timeout, start_write, start_read} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_status: got %b want 100000 (ready,rvalid,busy,tmo,sw,sr)",
                     {cmd_ready, rsp_valid, busy, timeout, start_write, start_read});
        end
        n_vec++;
        if ({addr_in, data_in} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_addr_data: got %h/%h want 0/0", addr_in, data_in);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_write_read;
        bit ok1, ok2, okr; logic w, e; logic [31:0] d; int s0w, s0r;
        master_en = 1'b1; rsp_ready = 1'b0;
        s0w = sw_cnt; s0r = sr_cnt;
        push_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, ok1);
        push_cmd(1'b0, 32'h4, 32'h0, ok2);
        n_vec++;
        if ({ok1, ok2} !== 2'b11) begin n_err++; $display("FAIL wr_rd_accept: got %b want 11", {ok1, ok2}); end
        pop_rsp(w, e, d, okr);
        n_vec++;
        if ({okr, w, e, d} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp: got ok=%b w=%b e=%b d=%h want 1 1 0 00000000", okr, w, e, d);
        end
        pop_rsp(w, e, d, okr);
        n_vec++;
        if ({okr, w, e, d} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL rd_rsp: got ok=%b w=%b e=%b d=%h want 1 0 0 deadbeef", okr, w, e, d);
        end
        wait_idle(okr);
        n_vec++;
        if (okr !== 1'b1 || sw_cnt - s0w != 1 || sr_cnt - s0r != 1) begin
            n_err++; $display("FAIL wr_rd_pulses: got idle=%b sw=%0d sr=%0d want 1 1 1", okr, sw_cnt - s0w, sr_cnt - s0r);
        end
    endtask

    task automatic test_cmd_full;
        bit ok, all_ok; logic w, e; logic [31:0] d;
        wait_idle(ok);
        master_en = 1'b1; man_done = 1'b1; rsp_ready = 1'b0; all_ok = ok;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b1, 32'h10 + 32'(4 * i), 32'h1000_0000 + 32'(i), ok);
            all_ok &= ok;
        end
        n_vec++;
        if ({all_ok, cmd_ready, busy, start_write} !== 4'b1010) begin
            n_err++; $display("FAIL full_after4: got ok,ready,busy,sw=%b want 1010", {all_ok, cmd_ready, busy, start_write});
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1000_0004;
        tick(3);
        n_vec++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_hold: got ready=%b want 0", cmd_ready); end
        man_done = 1'b0;
        tick(1);
        n_vec++;
        if ({start_write, cmd_ready, addr_in} !== {1'b1, 1'b1, 32'h10}) begin
            n_err++; $display("FAIL full_first_issue: got sw=%b ready=%b addr=%h want 1 1 00000010", start_write, cmd_ready, addr_in);
        end
        tick(1);
        cmd_valid = 1'b0;
        n_vec++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_fifth_taken: got ready=%b want 0", cmd_ready); end
        for (int i = 0; i < 5; i++) begin
            pop_rsp(w, e, d, ok);
            n_vec++;
            if ({ok, w, e, d} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
                n_err++; $display("FAIL full_rsp%0d: got ok=%b w=%b e=%b d=%h want 1 1 0 00000000", i, ok, w, e, d);
            end
        end
    endtask

    task automatic test_rsp_backpressure;
        bit ok, all_ok; logic w, e; logic [31:0] d; int s0r;
        wait_idle(ok);
        rsp_ready = 1'b0; all_ok = ok; s0r = sr_cnt;
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0, ok);
            all_ok &= ok;
        end
        tick(30);
        n_vec++;
        if ({all_ok, rsp_valid, busy} !== 3'b111 || sr_cnt - s0r != 2) begin
            n_err++; $display("FAIL bp_two_issued: got ok,rvalid,busy=%b reads=%0d want 111 2", {all_ok, rsp_valid, busy}, sr_cnt - s0r);
        end
        n_vec++;
        if ({rsp_write, rsp_error, rsp_rdata} !== {1'b0, 1'b0, 32'h1000_0000}) begin
            n_err++; $display("FAIL bp_head: got w=%b e=%b d=%h want 0 0 10000000", rsp_write, rsp_error, rsp_rdata);
        end
        tick(2);
        n_vec++;
        if ({rsp_valid, rsp_write, rsp_error, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h1000_0000}) begin
            n_err++; $display("FAIL bp_head_stable: got v=%b w=%b e=%b d=%h want 1 0 0 10000000", rsp_valid, rsp_write, rsp_error, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        n_vec++;
        if (start_read !== 1'b0 || sr_cnt - s0r != 2) begin
            n_err++; $display("FAIL bp_pop_edge: got sr=%b reads=%0d want 0 2", start_read, sr_cnt - s0r);
        end
        tick(1);
        n_vec++;
        if ({start_read, addr_in} !== {1'b1, 32'h18}) begin
            n_err++; $display("FAIL bp_third_issue: got sr=%b addr=%h want 1 00000018", start_read, addr_in);
        end
        for (int i = 1; i < 3; i++) begin
            pop_rsp(w, e, d, ok);
            n_vec++;
            if ({ok, w, e, d} !== {1'b1, 1'b0, 1'b0, 32'h1000_0000 + 32'(i)}) begin
                n_err++; $display("FAIL bp_rsp%0d: got ok=%b w=%b e=%b d=%h want 1 0 0 %h", i, ok, w, e, d, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_done_level;
        bit ok1, ok2, oks; logic w, e; logic [31:0] d; int s0w, s0r, early;
        wait_idle(ok1);
        master_en = 1'b0; rsp_ready = 1'b0; s0w = sw_cnt; s0r = sr_cnt; early = 0;
        push_cmd(1'b1, 32'h8, 32'h55AA_55AA, ok1);
        push_cmd(1'b0, 32'h8, 32'h0, ok2);
        wait_start(oks);
        n_vec++;
        if ({ok1, ok2, oks, start_write, addr_in} !== {4'b1111, 32'h8}) begin
            n_err++; $display("FAIL lvl_issue: got ok=%b%b%b sw=%b addr=%h want 111 1 00000008", ok1, ok2, oks, start_write, addr_in);
        end
        tick(2);
        man_done = 1'b1; man_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (start_read !== 1'b0) early++;
        end
        man_done = 1'b0;
        tick(1);
        n_vec++;
        if (early != 0 || start_read !== 1'b0) begin
            n_err++; $display("FAIL lvl_no_early_issue: got early=%0d sr=%b want 0 0", early, start_read);
        end
        tick(1);
        n_vec++;
        if (start_read !== 1'b1) begin n_err++; $display("FAIL lvl_issue_after_fall: got sr=%b want 1", start_read); end
        pop_rsp(w, e, d, ok1);
        n_vec++;
        if ({ok1, w, e, d, rsp_valid} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL lvl_one_rsp: got ok=%b w=%b e=%b d=%h more=%b want 1 1 0 00000000 0", ok1, w, e, d, rsp_valid);
        end
        man_done = 1'b1; err_drv = 1'b1; man_data = 32'h1234_5678;
        tick(1);
        man_done = 1'b0; err_drv = 1'b0;
        pop_rsp(w, e, d, ok1);
        n_vec++;
        if ({ok1, w, e, d} !== {1'b1, 1'b0, 1'b1, 32'h1234_5678} || sw_cnt - s0w != 1 || sr_cnt - s0r != 1) begin
            n_err++; $display("FAIL lvl_err_rsp: got ok=%b w=%b e=%b d=%h sw=%0d sr=%0d want 1 0 1 12345678 1 1",
                              ok1, w, e, d, sw_cnt - s0w, sr_cnt - s0r);
        end
    endtask

    task automatic test_timeout;
        bit ok, all_ok; logic w, e; logic [31:0] d; int s0w, s0r;
        wait_idle(ok);
        master_en = 1'b0; rsp_ready = 1'b0; all_ok = ok;
        push_cmd(1'b1, 32'h30, 32'hCAFE_0000, ok); all_ok &= ok;
        wait_start(ok); all_ok &= ok;
        push_cmd(1'b0, 32'h30, 32'h0, ok); all_ok &= ok;
        push_cmd(1'b0, 32'h34, 32'h0, ok); all_ok &= ok;
        tick(14);
        n_vec++;
        if ({all_ok, timeout, rsp_valid} !== 3'b100) begin
            n_err++; $display("FAIL tmo_cycle16: got ok,tmo,rvalid=%b want 100", {all_ok, timeout, rsp_valid});
        end
        tick(1);
        n_vec++;
        if ({timeout, rsp_valid, rsp_write, rsp_error, rsp_rdata} !== {4'b1111, 32'h0}) begin
            n_err++; $display("FAIL tmo_expired: got tmo=%b v=%b w=%b e=%b d=%h want 1 1 1 1 00000000",
                              timeout, rsp_valid, rsp_write, rsp_error, rsp_rdata);
        end
        s0w = sw_cnt; s0r = sr_cnt;
        pop_rsp(w, e, d, ok);
        tick(30);
        n_vec++;
        if ({ok, busy, timeout, rsp_valid} !== 4'b1110 || sw_cnt != s0w || sr_cnt != s0r) begin
            n_err++; $display("FAIL tmo_halt: got ok,busy,tmo,rvalid=%b starts=%0d want 1110 0",
                              {ok, busy, timeout, rsp_valid}, (sw_cnt - s0w) + (sr_cnt - s0r));
        end
        all_ok = 1'b1;
        push_cmd(1'b1, 32'h38, 32'h1, ok); all_ok &= ok;
        push_cmd(1'b1, 32'h3C, 32'h2, ok); all_ok &= ok;
        n_vec++;
        if ({all_ok, cmd_ready, start_write, start_read} !== 4'b1000) begin
            n_err++; $display("FAIL tmo_halt_fill: got ok,ready,sw,sr=%b want 1000", {all_ok, cmd_ready, start_write, start_read});
        end
    endtask

    task automatic test_reset_in_wait;
        bit ok, all_ok; int s0w, s0r;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_vec++;
        if ({timeout, busy, cmd_ready} !== 3'b001) begin
            n_err++; $display("FAIL rst_from_halt: got tmo,busy,ready=%b want 001", {timeout, busy, cmd_ready});
        end
        master_en = 1'b0; all_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0, ok);
            all_ok &= ok;
        end
        tick(3);
        n_vec++;
        if ({all_ok, busy, start_write, start_read, rsp_valid} !== 5'b11000) begin
            n_err++; $display("FAIL rst_pre_wait: got ok,busy,sw,sr,rvalid=%b want 11000", {all_ok, busy, start_write, start_read, rsp_valid});
        end
        rst = 1'b1;
        tick(1);
        n_vec++;
        if ({busy, cmd_ready, rsp_valid, timeout, start_write, start_read} !== 6'b010000 || addr_in !== 32'h0) begin
            n_err++; $display("FAIL rst_in_wait: got busy,ready,rvalid,tmo,sw,sr=%b addr=%h want 010000 00000000",
                              {busy, cmd_ready, rsp_valid, timeout, start_write, start_read}, addr_in);
        end
        rst = 1'b0;
        s0w = sw_cnt; s0r = sr_cnt;
        tick(10);
        n_vec++;
        if (busy !== 1'b0 || sw_cnt != s0w || sr_cnt != s0r) begin
            n_err++; $display("FAIL rst_fifo_flushed: got busy=%b starts=%0d want 0 0", busy, (sw_cnt - s0w) + (sr_cnt - s0r));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; err_drv = 1'b0;
        test_reset;
        test_write_read;
        test_cmd_full;
        test_rsp_backpressure;
        test_done_level;
        test_timeout;
        test_reset_in_wait;
        n_vec++;
        if (pulse_err != 0) begin
            n_err++; $display("FAIL start_pulse_shape: got %0d bad pulses want 0", pulse_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
